// File: rtl/rotary_angle_input.sv
// Rotary-encoder front end: synchronises and debounces the quadrature encoder
// channels and push button, tracks a 0..MAX_ANGLE angle with an incrementally
// maintained BCD/ASCII display word, and emits a one-cycle confirm pulse.
//
// Output semantics: `press` is a registered single-cycle strobe with no
// ready/acknowledge; the consumer must sample it on the cycle it is high.
// `angle` and `angle_disp` are registered levels, always mutually consistent,
// and hold their value outside TRACK. `state_dbg` mirrors the FSM state
// (0 = IDLE, 1 = TRACK, 2 = DONE) for observation only.
module rotary_angle_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_ANGLE       = 359
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_on,
    input  logic        rotary_a,
    input  logic        rotary_b,
    input  logic        rotary_press,
    output logic [8:0]  angle,
    output logic [23:0] angle_disp,
    output logic        press,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int            CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Wrap targets for the angle and its decimal digits.
    localparam logic [8:0] ANGLE_MAX = 9'(MAX_ANGLE);
    localparam logic [3:0] MAX_H     = 4'(MAX_ANGLE / 100);
    localparam logic [3:0] MAX_T     = 4'((MAX_ANGLE / 10) % 10);
    localparam logic [3:0] MAX_O     = 4'(MAX_ANGLE % 10);

    // Input bit positions inside the packed raw/sync/stable vectors.
    localparam int IDX_A     = 0;
    localparam int IDX_B     = 1;
    localparam int IDX_PRESS = 2;

    logic [2:0] raw_in;
    assign raw_in = {rotary_press, rotary_b, rotary_a};

    // ------------------------------------------------------------------
    // Synchroniser and debouncer state
    // ------------------------------------------------------------------
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    stable_prev_q, stable_prev_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    // Two-flop synchroniser for each raw asynchronous input.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // Debounce: a differing synchronised level must persist until the
    // counter has reached DEBOUNCE_CYCLES-1 before the stable value follows.
    always_comb begin
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Register stage for synchronisers, debounce counters and stable levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Rising-edge strobes on the debounced A and press levels.
    logic a_rise;
    logic press_rise;
    logic b_level;
    assign a_rise     = stable_q[IDX_A] & ~stable_prev_q[IDX_A];
    assign press_rise = stable_q[IDX_PRESS] & ~stable_prev_q[IDX_PRESS];
    assign b_level    = stable_q[IDX_B];

    // ------------------------------------------------------------------
    // Angle tracking FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [8:0] angle_q;
    logic [3:0] dig_h_q, dig_t_q, dig_o_q;
    logic       press_q;

    logic [8:0] inc_angle_d, dec_angle_d;
    logic [3:0] inc_h_d, inc_t_d, inc_o_d;
    logic [3:0] dec_h_d, dec_t_d, dec_o_d;

    // Next angle and digits for one clockwise step (carry ripples upward).
    always_comb begin
        inc_angle_d = angle_q;
        inc_h_d     = dig_h_q;
        inc_t_d     = dig_t_q;
        inc_o_d     = dig_o_q;
        if (angle_q == ANGLE_MAX) begin
            inc_angle_d = '0;
            inc_h_d     = 4'd0;
            inc_t_d     = 4'd0;
            inc_o_d     = 4'd0;
        end else begin
            inc_angle_d = angle_q + 9'd1;
            if (dig_o_q == 4'd9) begin
                inc_o_d = 4'd0;
                if (dig_t_q == 4'd9) begin
                    inc_t_d = 4'd0;
                    inc_h_d = dig_h_q + 4'd1;
                end else begin
                    inc_t_d = dig_t_q + 4'd1;
                end
            end else begin
                inc_o_d = dig_o_q + 4'd1;
            end
        end
    end

    // Next angle and digits for one counter-clockwise step (borrow ripples upward).
    always_comb begin
        dec_angle_d = angle_q;
        dec_h_d     = dig_h_q;
        dec_t_d     = dig_t_q;
        dec_o_d     = dig_o_q;
        if (angle_q == 9'd0) begin
            dec_angle_d = ANGLE_MAX;
            dec_h_d     = MAX_H;
            dec_t_d     = MAX_T;
            dec_o_d     = MAX_O;
        end else begin
            dec_angle_d = angle_q - 9'd1;
            if (dig_o_q == 4'd0) begin
                dec_o_d = 4'd9;
                if (dig_t_q == 4'd0) begin
                    dec_t_d = 4'd9;
                    dec_h_d = dig_h_q - 4'd1;
                end else begin
                    dec_t_d = dig_t_q - 4'd1;
                end
            end else begin
                dec_o_d = dig_o_q - 4'd1;
            end
        end
    end

    // FSM with registered angle, digits and press strobe. A step and a
    // press rise in the same cycle are both honoured, so the frozen angle
    // includes that final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            angle_q <= '0;
            dig_h_q <= 4'd0;
            dig_t_q <= 4'd0;
            dig_o_q <= 4'd0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dev_on) begin
                        state_q <= ST_TRACK;
                        angle_q <= '0;
                        dig_h_q <= 4'd0;
                        dig_t_q <= 4'd0;
                        dig_o_q <= 4'd0;
                    end
                end
                ST_TRACK: begin
                    if (!dev_on) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (a_rise) begin
                            if (!b_level) begin
                                angle_q <= inc_angle_d;
                                dig_h_q <= inc_h_d;
                                dig_t_q <= inc_t_d;
                                dig_o_q <= inc_o_d;
                            end else begin
                                angle_q <= dec_angle_d;
                                dig_h_q <= dec_h_d;
                                dig_t_q <= dec_t_d;
                                dig_o_q <= dec_o_d;
                            end
                        end
                        if (press_rise) begin
                            press_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!dev_on) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign angle      = angle_q;
    assign angle_disp = {4'h3, dig_h_q, 4'h3, dig_t_q, 4'h3, dig_o_q};
    assign press      = press_q;
    assign state_dbg  = state_q;

endmodule
